// File: rtl/u110_pci_target.sv
// AmigaPCI U110 PCI target: single-data-phase memory responder with medium DEVSEL,
// disconnect-after-one-phase, target-retry on slow local side, and read parity.
module u110_pci_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
    parameter logic [31:0] WIN_MASK    = 32'hF800_0000,
    parameter int          RETRY_LIMIT = 16
) (
    input  logic        CLK33,
    input  logic        RESET,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic [3:0]  C_BEn,
    input  logic [31:0] AD_IN,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        DEVSELn,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        CTL_OE,
    output logic        PAR_OUT,
    output logic        PAR_OE,
    output logic        LCL_REQ,
    output logic        LCL_RnW,
    output logic [31:0] LCL_ADDR,
    output logic [3:0]  LCL_BE,
    output logic [31:0] LCL_WDATA,
    input  logic [31:0] LCL_RDATA,
    input  logic        LCL_ACK
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY   = 3'd1,
        S_DECODE = 3'd2,
        S_WAITI  = 3'd3,
        S_LOCAL  = 3'd4,
        S_DATA   = 3'd5,
        S_STOPW  = 3'd6,
        S_TURN   = 3'd7
    } state_t;

    localparam logic [4:0] LIMIT = 5'(RETRY_LIMIT);

    function automatic logic calc_par(input logic [31:0] d, input logic [3:0] c);
        return ^{d, c};
    endfunction

    state_t      r_state, w_next;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic        r_idle_seen, w_idle_seen_nxt;
    logic [31:0] r_ad_out, w_ad_out_nxt;
    logic        r_ad_oe, w_ad_oe_nxt;
    logic        r_devsel_n, w_devsel_n_nxt;
    logic        r_trdy_n, w_trdy_n_nxt;
    logic        r_stop_n, w_stop_n_nxt;
    logic        r_ctl_oe, w_ctl_oe_nxt;
    logic        r_par_out, w_par_out_nxt;
    logic        r_par_oe, w_par_oe_nxt;
    logic        r_req, w_req_nxt;
    logic        r_rnw, w_rnw_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [3:0]  r_be, w_be_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;

    logic w_addr_ph, w_cmd_rd, w_cmd_wr, w_hit, w_timeout, w_bus_idle, w_complete;

    assign w_bus_idle = FRAMEn && IRDYn;
    assign w_addr_ph  = (r_state == S_IDLE) && !FRAMEn && r_idle_seen;
    assign w_cmd_rd   = (C_BEn == 4'b0110) || (C_BEn == 4'b1100) || (C_BEn == 4'b1110);
    assign w_cmd_wr   = (C_BEn == 4'b0111);
    assign w_hit      = (w_cmd_rd || w_cmd_wr) && ((AD_IN & WIN_MASK) == (BASE_ADDR & WIN_MASK));
    assign w_timeout  = (r_cnt == LIMIT);
    assign w_complete = (r_state == S_DATA) && !IRDYn;

    // State and all output registers
    always_ff @(posedge CLK33) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_idle_seen <= 1'b0;
            r_ad_out    <= 32'd0;
            r_ad_oe     <= 1'b0;
            r_devsel_n  <= 1'b1;
            r_trdy_n    <= 1'b1;
            r_stop_n    <= 1'b1;
            r_ctl_oe    <= 1'b0;
            r_par_out   <= 1'b0;
            r_par_oe    <= 1'b0;
            r_req       <= 1'b0;
            r_rnw       <= 1'b1;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_idle_seen <= w_idle_seen_nxt;
            r_ad_out    <= w_ad_out_nxt;
            r_ad_oe     <= w_ad_oe_nxt;
            r_devsel_n  <= w_devsel_n_nxt;
            r_trdy_n    <= w_trdy_n_nxt;
            r_stop_n    <= w_stop_n_nxt;
            r_ctl_oe    <= w_ctl_oe_nxt;
            r_par_out   <= w_par_out_nxt;
            r_par_oe    <= w_par_oe_nxt;
            r_req       <= w_req_nxt;
            r_rnw       <= w_rnw_nxt;
            r_addr      <= w_addr_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    // Next-state decode; ACK is tested before timeout so a coincident ACK completes
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_addr_ph) w_next = w_hit ? S_DECODE : S_BUSY;
                else           w_next = S_IDLE;
            end
            S_BUSY: begin
                if (w_bus_idle) w_next = S_IDLE;
                else            w_next = S_BUSY;
            end
            S_DECODE: w_next = S_WAITI;
            S_WAITI: begin
                if (w_bus_idle)  w_next = S_TURN;
                else if (w_timeout) w_next = S_STOPW;
                else if (!IRDYn) w_next = S_LOCAL;
                else             w_next = S_WAITI;
            end
            S_LOCAL: begin
                if (LCL_ACK)        w_next = S_DATA;
                else if (w_timeout) w_next = S_STOPW;
                else                w_next = S_LOCAL;
            end
            S_DATA: begin
                if (!IRDYn) w_next = r_stop_n ? S_TURN : S_STOPW;
                else        w_next = S_DATA;
            end
            S_STOPW: begin
                if (FRAMEn) w_next = S_TURN;
                else        w_next = S_STOPW;
            end
            S_TURN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        w_devsel_n_nxt  = !((w_next == S_WAITI) || (w_next == S_LOCAL) ||
                            (w_next == S_DATA)  || (w_next == S_STOPW));
        w_ctl_oe_nxt    = !w_devsel_n_nxt || (w_next == S_TURN);
        w_trdy_n_nxt    = (w_next != S_DATA);
        w_req_nxt       = (w_next == S_LOCAL);
        w_ad_oe_nxt     = (w_next == S_DATA) && r_rnw;
        w_idle_seen_nxt = (r_state == S_IDLE) && w_bus_idle;

        if (w_next == S_STOPW)      w_stop_n_nxt = 1'b0;
        else if (w_next == S_DATA)  w_stop_n_nxt = (r_state == S_LOCAL) ? FRAMEn : r_stop_n;
        else                        w_stop_n_nxt = 1'b1;

        if ((r_state == S_LOCAL) && LCL_ACK && r_rnw) w_ad_out_nxt = LCL_RDATA;
        else                                          w_ad_out_nxt = r_ad_out;

        w_par_oe_nxt = w_complete && r_rnw;
        if (w_par_oe_nxt) w_par_out_nxt = calc_par(r_ad_out, C_BEn);
        else              w_par_out_nxt = r_par_out;

        if (w_addr_ph && w_hit) begin
            w_addr_nxt = {AD_IN[31:2], 2'b00};
            w_rnw_nxt  = w_cmd_rd;
        end else begin
            w_addr_nxt = r_addr;
            w_rnw_nxt  = r_rnw;
        end

        if ((r_state == S_WAITI) && (w_next == S_LOCAL)) begin
            w_be_nxt    = ~C_BEn;
            w_wdata_nxt = r_rnw ? r_wdata : AD_IN;
        end else begin
            w_be_nxt    = r_be;
            w_wdata_nxt = r_wdata;
        end

        // Counter value k+1 after edge A+k, so the limit is seen at edge A+RETRY_LIMIT
        if (w_addr_ph)
            w_cnt_nxt = 5'd1;
        else if (((r_state == S_DECODE) || (r_state == S_WAITI) || (r_state == S_LOCAL)) &&
                 (r_cnt != 5'd31))
            w_cnt_nxt = r_cnt + 5'd1;
        else if (r_state == S_IDLE)
            w_cnt_nxt = 5'd0;
        else
            w_cnt_nxt = r_cnt;
    end

    assign AD_OUT    = r_ad_out;
    assign AD_OE     = r_ad_oe;
    assign DEVSELn   = r_devsel_n;
    assign TRDYn     = r_trdy_n;
    assign STOPn     = r_stop_n;
    assign CTL_OE    = r_ctl_oe;
    assign PAR_OUT   = r_par_out;
    assign PAR_OE    = r_par_oe;
    assign LCL_REQ   = r_req;
    assign LCL_RnW   = r_rnw;
    assign LCL_ADDR  = r_addr;
    assign LCL_BE    = r_be;
    assign LCL_WDATA = r_wdata;

endmodule

// File: tb/tb_u110_pci_target.sv
// Directed bench for u110_pci_target: table of single transactions plus
// hand-written retry, ACK/timeout race, abandon and mid-cycle reset sequences.
module tb_u110_pci_target;

    logic        CLK33 = 1'b0;
    logic        RESET, FRAMEn, IRDYn, LCL_ACK;
    logic [3:0]  C_BEn;
    logic [31:0] AD_IN, LCL_RDATA;
    logic [31:0] AD_OUT, LCL_ADDR, LCL_WDATA;
    logic [3:0]  LCL_BE;
    logic        AD_OE, DEVSELn, TRDYn, STOPn, CTL_OE, PAR_OUT, PAR_OE, LCL_REQ, LCL_RnW;

    int n_chk  = 0;
    int n_fail = 0;

    u110_pci_target dut (
        .CLK33(CLK33), .RESET(RESET), .FRAMEn(FRAMEn), .IRDYn(IRDYn), .C_BEn(C_BEn),
        .AD_IN(AD_IN), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .DEVSELn(DEVSELn), .TRDYn(TRDYn),
        .STOPn(STOPn), .CTL_OE(CTL_OE), .PAR_OUT(PAR_OUT), .PAR_OE(PAR_OE),
        .LCL_REQ(LCL_REQ), .LCL_RnW(LCL_RnW), .LCL_ADDR(LCL_ADDR), .LCL_BE(LCL_BE),
        .LCL_WDATA(LCL_WDATA), .LCL_RDATA(LCL_RDATA), .LCL_ACK(LCL_ACK)
    );

    always #15 CLK33 = ~CLK33;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic        burst;
        logic        hit;
        logic        rnw;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge CLK33);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ad_out"}, AD_OUT, 32'd0);
        chk({tag, "_ad_oe"}, {31'd0, AD_OE}, 32'd0);
        chk({tag, "_ctl"}, {28'd0, DEVSELn, TRDYn, STOPn, CTL_OE}, 32'hE);
        chk({tag, "_par"}, {30'd0, PAR_OUT, PAR_OE}, 32'd0);
        chk({tag, "_req_rnw"}, {30'd0, LCL_REQ, LCL_RnW}, 32'd1);
        chk({tag, "_laddr"}, LCL_ADDR, 32'd0);
        chk({tag, "_lbe"}, {28'd0, LCL_BE}, 32'd0);
        chk({tag, "_lwdata"}, LCL_WDATA, 32'd0);
    endtask

    task automatic bus_idle();
        FRAMEn = 1'b1; IRDYn = 1'b1; LCL_ACK = 1'b0;
        C_BEn = 4'hF; AD_IN = 32'd0;
    endtask

    // Idle clock, address phase at edge A, then IRDY driven after A+1; returns at A+2
    task automatic start_read(input logic [31:0] addr, input logic [3:0] cmd, input logic frame_hold);
        bus_idle();
        tick();
        FRAMEn = 1'b0; AD_IN = addr; C_BEn = cmd;
        tick();
        tick();
        FRAMEn = frame_hold ? 1'b0 : 1'b1; IRDYn = 1'b0; C_BEn = 4'b0000; AD_IN = 32'd0;
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string n;
        n = $sformatf("v%0d", idx);
        bus_idle();
        tick();
        FRAMEn = 1'b0; AD_IN = v.addr; C_BEn = v.cmd;
        tick();                                  // edge A
        tick();                                  // edge A+1
        chk({n, "_ctl_oe_a1"}, {31'd0, CTL_OE}, {31'd0, v.hit});
        chk({n, "_devsel_a1"}, {31'd0, DEVSELn}, {31'd0, ~v.hit});
        FRAMEn = v.burst ? 1'b0 : 1'b1; IRDYn = 1'b0; C_BEn = v.be;
        AD_IN = v.rnw ? 32'd0 : v.wdata;
        tick();                                  // edge A+2
        if (!v.hit) begin
            chk({n, "_miss_ctl"}, {30'd0, CTL_OE, LCL_REQ}, 32'd0);
            IRDYn = 1'b1;
            tick();
            chk({n, "_miss_ctl2"}, {30'd0, CTL_OE, LCL_REQ}, 32'd0);
            tick();
        end else begin
            chk({n, "_req"}, {31'd0, LCL_REQ}, 32'd1);
            chk({n, "_rnw"}, {31'd0, LCL_RnW}, {31'd0, v.rnw});
            chk({n, "_laddr"}, LCL_ADDR, v.exp_addr);
            chk({n, "_lbe"}, {28'd0, LCL_BE}, {28'd0, v.exp_be});
            if (!v.rnw) chk({n, "_wdata"}, LCL_WDATA, v.wdata);
            for (int i = 0; i < v.ack_dly; i++) begin
                tick();
                chk({n, "_wait_trdy"}, {30'd0, TRDYn, LCL_REQ}, 32'd3);
            end
            LCL_ACK = 1'b1; LCL_RDATA = v.rdata;
            tick();                              // ACK sampled
            LCL_ACK = 1'b0; LCL_RDATA = 32'd0;
            chk({n, "_trdy"}, {29'd0, TRDYn, STOPn, LCL_REQ}, {29'd0, 1'b0, ~v.burst, 1'b0});
            chk({n, "_ad_oe"}, {31'd0, AD_OE}, {31'd0, v.rnw});
            if (v.rnw) chk({n, "_ad_out"}, AD_OUT, v.rdata);
            tick();                              // completion edge
            chk({n, "_done"}, {28'd0, TRDYn, AD_OE, PAR_OE, STOPn},
                {28'd0, 1'b1, 1'b0, v.rnw, ~v.burst});
            if (v.rnw) chk({n, "_par"}, {31'd0, PAR_OUT}, {31'd0, ^{v.rdata, v.be}});
            FRAMEn = 1'b1; IRDYn = 1'b1;
            if (v.burst) begin
                tick();                          // STOPW saw FRAMEn=1
                chk({n, "_turn"}, {28'd0, DEVSELn, TRDYn, STOPn, CTL_OE}, 32'hF);
            end
            tick();
            chk({n, "_end"}, {30'd0, CTL_OE, PAR_OE}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0800_0010, 4'b0110, 4'b0000, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 1'b1,
                    32'h0800_0010, 4'b1111};
        vecs[1] = '{32'h0800_0004, 4'b0111, 4'b1100, 32'h1234_5678, 32'd0, 2, 1'b0, 1'b1, 1'b0,
                    32'h0800_0004, 4'b0011};
        vecs[2] = '{32'h0FFF_FFFE, 4'b1100, 4'b0101, 32'd0, 32'hA5A5_0F0F, 0, 1'b1, 1'b1, 1'b1,
                    32'h0FFF_FFFC, 4'b1010};
        vecs[3] = '{32'h0800_0008, 4'b0111, 4'b0000, 32'hCAFE_F00D, 32'd0, 3, 1'b1, 1'b1, 1'b0,
                    32'h0800_0008, 4'b1111};
        vecs[4] = '{32'h1000_0000, 4'b0110, 4'b0000, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b1,
                    32'd0, 4'd0};
        vecs[5] = '{32'h0800_0000, 4'b0010, 4'b0000, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b1,
                    32'd0, 4'd0};
        vecs[6] = '{32'h0BFF_FFF0, 4'b1110, 4'b1111, 32'd0, 32'h0000_0001, 0, 1'b0, 1'b1, 1'b1,
                    32'h0BFF_FFF0, 4'b0000};

        RESET = 1'b1; LCL_RDATA = 32'd0;
        bus_idle();
        tick(); tick(); tick();
        chk_reset_vals("rst");
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Retry: no ACK, abort at A+16; a late ACK must be ignored
        start_read(32'h0800_0040, 4'b0110, 1'b0);          // now at A+2
        for (int i = 0; i < 13; i++) tick();                // A+15
        chk("retry_pre", {30'd0, LCL_REQ, STOPn}, 32'd3);
        tick();                                             // A+16
        chk("retry_abort", {28'd0, LCL_REQ, STOPn, TRDYn, DEVSELn}, 32'h2);
        IRDYn = 1'b1; LCL_ACK = 1'b1; LCL_RDATA = 32'h1111_2222;
        tick();
        LCL_ACK = 1'b0;
        chk("retry_turn", {27'd0, DEVSELn, TRDYn, STOPn, CTL_OE, AD_OE}, 32'h1E);
        tick();
        chk("retry_idle", {31'd0, CTL_OE}, 32'd0);

        // ACK sampled on the timeout edge: ACK wins
        start_read(32'h0800_0080, 4'b0110, 1'b0);
        for (int i = 0; i < 13; i++) tick();
        LCL_ACK = 1'b1; LCL_RDATA = 32'h600D_F00D;
        tick();                                             // A+16
        LCL_ACK = 1'b0;
        chk("race_trdy", {29'd0, TRDYn, STOPn, LCL_REQ}, 32'h2);
        chk("race_data", AD_OUT, 32'h600D_F00D);
        tick();
        chk("race_done", {30'd0, TRDYn, PAR_OE}, 32'h3);
        chk("race_par", {31'd0, PAR_OUT}, {31'd0, ^{32'h600D_F00D, 4'b0000}});
        bus_idle();
        tick();

        // Master abandon in WAITI: TURN without a local request
        bus_idle();
        tick();
        FRAMEn = 1'b0; AD_IN = 32'h0800_0100; C_BEn = 4'b0110;
        tick(); tick();
        bus_idle();
        tick();
        chk("abandon_turn", {29'd0, DEVSELn, CTL_OE, LCL_REQ}, 32'h6);
        tick();
        chk("abandon_idle", {31'd0, CTL_OE}, 32'd0);

        // Reset while waiting on the local side
        start_read(32'h0800_0200, 4'b1100, 1'b0);
        tick();
        chk("pre_reset_req", {31'd0, LCL_REQ}, 32'd1);
        RESET = 1'b1;
        tick();
        chk_reset_vals("midrst");
        RESET = 1'b0;
        bus_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
